mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the multicycle CPU's single-port unified 16-bit memory (`mem`: synchronous write, combinational read). It shares the memory between the instruction-fetch unit (read-only, port 0) and the load/store unit (read/write, port 1). Each requester sees a req/ack handshake with registered read data. Sits between the control FSM's fetch/memory stages and the `mem` instance in the top level.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch request; hold with f_addr until f_ack
- f_addr  in  AW  fetch address
- f_ack  out  1  one-cycle pulse, f_rdata valid in the same cycle
- f_rdata  out  DW  registered fetch data, held until next fetch completes
- d_req  in  1  data request; hold with d_addr/d_we/d_wd until d_ack
- d_addr  in  AW  data address
- d_we  in  1  1 = store, 0 = load
- d_wd  in  DW  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DW  registered load data; not updated by stores
- mem_a  out  AW  to `mem` a
- mem_we  out  1  to `mem` we
- mem_wd  out  DW  to `mem` wd
- mem_rd  in  DW  from `mem` rd

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req high, pick winner, latch its addr/we/wd into a_q/we_q/wd_q and owner, set last = owner, go ACCESS. Fetch always latches we_q = 0. No req: stay IDLE.
- ACCESS: mem_a = a_q, mem_wd = wd_q, mem_we = we_q & ~reset. At the end of the cycle the memory writes if we_q; if !we_q, mem_rd is captured into the owner's rdata register. Go DONE.
- DONE: owner's ack = 1 for this cycle only. Other req ignored. Go IDLE.
- Arbitration (default, round-robin): only one req high → that port wins. Both high → the port != last wins. Reset sets last = port 1, so port 0 wins the first tie.
- Outputs outside ACCESS: mem_we = 0. mem_a and mem_wd hold a_q and wd_q.
- A loser's request stays pending and is served on the next IDLE visit. Requesters must not change their request fields while req is high and ack is not yet seen.
- A requester that drops req before ack is a protocol violation. The latched transaction still completes and acks.

## Timing
- Reset values: state = IDLE, f_ack = d_ack = 0, f_rdata = d_rdata = 0, mem_we = 0, a_q = wd_q = 0, we_q = 0, last = 1.
- Latency: req sampled high in IDLE at cycle N, ACCESS in N+1, ack plus valid rdata in N+2.
- Throughput: one transaction per 3 cycles. A requester re-asserting req in N+3 (its first cycle after seeing ack) is sampled in IDLE at N+3.
- Both req held continuously: grants alternate f, d, f, d…, one ack every 3 cycles.
- Reset high during ACCESS: mem_we is forced 0 combinationally, so no write occurs. No ack is issued. State is IDLE after the edge.
- Reset high during DONE: ack is still visible in that cycle (registered), then cleared.
- Store followed by load to the same address: the load returns the stored value, because the write completes at the end of the store's ACCESS cycle.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority. The data port always wins a tie, and `last` is not used for selection. This is starvation-prone for fetch, but the multicycle control FSM never holds d_req across fetches.
- Undefined (default): round-robin as above.
- No port or latency difference between the two builds.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - port index constants PORT_F = 1'b0 and PORT_D = 1'b1.
- Single module, no sub-modules. The winner pick is a small combinational block inside mem_arbiter.
- The top level instantiates mem_arbiter alongside the existing `mem`.

## Test plan
- Reset: hold reset 2 cycles → all outputs 0. Release with no req → state stays IDLE and mem_we stays 0.
- Single store then load: d_req, d_we = 1, d_addr = 25, d_wd = 16'habcd → mem_we = 1 only in cycle N+1, d_ack in N+2. Then load addr 25 → d_rdata = 16'habcd at its ack.
- Fetch isolation: preload addr 10 = 16'h1234, fetch addr 10 → f_ack at N+2, f_rdata = 16'h1234, d_rdata unchanged.
- Contention: f_req and d_req both high from cycle 0 → f_ack at cycle 2, d_ack at cycle 5. With MEM_ARB_FIXED_PRIO_EN, d_ack at 2 and f_ack at 5.
- Sustained contention: both req re-asserted immediately after each ack for 12 cycles → acks alternate f, d, f, d with no gaps beyond 3 cycles.
- Reset mid-op: store 16'hbeef to addr 5 with reset asserted during ACCESS → no ack. A subsequent load of addr 5 returns the old contents, not 16'hbeef.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port memory between fetch (port 0) and load/store (port 1).
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed data-port priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [DW-1:0] d_wd,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  state_t        state;
  logic [AW-1:0] a_q;
  logic [DW-1:0] wd_q;
  logic          we_q;
  logic          owner;
  logic          last;
  logic          win;

  // Winner of the current request set; only meaningful when some req is high.
  always_comb begin
    win = PORT_F;
    if (f_req && d_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = PORT_D;
`else
      win = ~last;
`endif
    end else if (d_req) begin
      win = PORT_D;
    end
  end

  // Reset gates the strobe combinationally so an interrupted store never lands.
  assign mem_a  = a_q;
  assign mem_wd = wd_q;
  assign mem_we = (state == ACCESS) & we_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      owner   <= PORT_F;
      last    <= PORT_D;
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            owner <= win;
            last  <= win;
            if (win == PORT_D) begin
              a_q  <= d_addr;
              we_q <= d_we;
              wd_q <= d_wd;
            end else begin
              a_q  <= f_addr;
              we_q <= 1'b0;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (owner == PORT_D) d_rdata <= mem_rd;
            else                 f_rdata <= mem_rd;
          end
          if (owner == PORT_D) d_ack <= 1'b1;
          else                 f_ack <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
